// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: channel state encoding and
// elaboration-time helpers for the prescaler ratio and period saturation.
package tick_sched_pkg;

    typedef enum logic {
        CH_OFF = 1'b0,
        CH_RUN = 1'b1
    } ch_state_t;

    localparam int SAT_W = 32;

    // Returns 0 when the ratio is not exact, so the top can reject it.
    function automatic int prescale(input int clk_hz, input int base_hz);
        if (base_hz <= 0 || (clk_hz % base_hz) != 0) begin
            return 0;
        end
        return clk_hz / base_hz;
    endfunction

    function automatic logic [SAT_W-1:0] sat_period(input logic [SAT_W-1:0] p);
        return (p == '0) ? SAT_W'(1) : p;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: divides the shared base tick by a programmable
// period, deferring period changes on a running channel to its next wrap.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                wr,
    input  logic                wr_enable,
    input  logic [PERIOD_W-1:0] wr_period,
    output logic                pulse,
    output logic                pending
);

    ch_state_t           state;
    ch_state_t           state_next;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] shadow;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] new_period;
    logic                wrap;

    assign new_period = PERIOD_W'(sat_period(SAT_W'(wr_period)));
    assign wrap       = (state == CH_RUN) && tick && (cnt == period - 1'b1);

    // NOTE: state_next gets its default before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        if (wr) begin
            state_next = wr_enable ? CH_RUN : CH_OFF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CH_OFF;
            period  <= PERIOD_W'(1);
            shadow  <= PERIOD_W'(1);
            cnt     <= '0;
            pending <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state <= state_next;
            pulse <= wrap;
            if (wr && !wr_enable) begin
                cnt     <= '0;
                pending <= 1'b0;
            end else if (wr && state == CH_OFF) begin
                period <= new_period;
                cnt    <= '0;
            end else if (state == CH_RUN) begin
                if (wrap) begin
                    cnt <= '0;
                    // A write landing on the wrap itself governs the very next interval.
                    if (wr) begin
                        period <= new_period;
                    end else if (pending) begin
                        period  <= shadow;
                        pending <= 1'b0;
                    end
                end else begin
                    if (tick) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (wr) begin
                        shadow  <= new_period;
                        pending <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick generator: shared prescaler to a base tick, config
// decode with per-channel backpressure, and NUM_CH tick_channel instances.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CLK_SPEED_HZ = 1_000_000,
    parameter int BASE_HZ      = 1_000,
    parameter int NUM_CH       = 4,
    parameter int PERIOD_W     = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [PERIOD_W-1:0]                     cfg_period,
    input  logic                                    cfg_enable,
    output logic                                    tick_base,
    output logic [NUM_CH-1:0]                       pulse,
    output logic [NUM_CH-1:0]                       pending
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRESCALE = prescale(CLK_SPEED_HZ, BASE_HZ);
    localparam int PC_W     = (PRESCALE >= 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

    if (PRESCALE < 2 || NUM_CH < 1 || NUM_CH > 16) begin : g_bad_param
        $error("tick_scheduler: CLK_SPEED_HZ/BASE_HZ must be exact and >= 2, NUM_CH 1..16");
    end

    logic [PC_W-1:0]   pcnt;
    logic [NUM_CH-1:0] wr;
    logic              accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick_base) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick_base = (pcnt == PC_LAST);

    // Out-of-range channel numbers match nothing and stay ready.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign wr[gi] = accept && (cfg_ch == CH_W'(gi));

        tick_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_base),
            .wr        (wr[gi]),
            .wr_enable (cfg_enable),
            .wr_period (cfg_period),
            .pulse     (pulse[gi]),
            .pending   (pending[gi])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: every cycle is compared against a
// model that tracks channel wraps as absolute base-tick indices.
module tb_tick_scheduler;

    localparam int CLK_SPEED_HZ = 12;
    localparam int BASE_HZ      = 3;
    localparam int PRESCALE     = 4;
    localparam int NUM_CH       = 4;
    localparam int PERIOD_W     = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [1:0]          cfg_ch = '0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic                cfg_enable = 1'b0;
    logic                tick_base;
    logic [NUM_CH-1:0]   pulse;
    logic [NUM_CH-1:0]   pending;

    tick_scheduler #(
        .CLK_SPEED_HZ (CLK_SPEED_HZ),
        .BASE_HZ      (BASE_HZ),
        .NUM_CH       (NUM_CH),
        .PERIOD_W     (PERIOD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_enable (cfg_enable),
        .tick_base  (tick_base),
        .pulse      (pulse),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int n;  // cycle index since reset release; tick k lands on cycle k*PRESCALE+PRESCALE-1

    // Reference model: wraps expressed as absolute base-tick indices.
    bit m_on[NUM_CH];
    int m_per[NUM_CH];
    int m_shadow[NUM_CH];
    bit m_pend[NUM_CH];
    int m_next[NUM_CH];
    bit m_wrapped[NUM_CH];

    int last_pulse[NUM_CH];
    int last_interval[NUM_CH];
    int pulse_count[NUM_CH];
    bit pend_seen[NUM_CH];

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_on[i] = 0; m_per[i] = 1; m_shadow[i] = 1; m_pend[i] = 0;
            m_next[i] = 0; m_wrapped[i] = 0;
            last_pulse[i] = -1; last_interval[i] = 0; pulse_count[i] = 0; pend_seen[i] = 0;
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance.
    task automatic step(input bit v, input int ch, input int per, input bit en);
        logic [NUM_CH-1:0] exp_pulse;
        logic [NUM_CH-1:0] exp_pend;
        logic exp_tick;
        logic exp_ready;
        bit   acc;
        bit   wrap;
        bit   wr;
        int   sat;
        int   k;
        cfg_valid  = v;
        cfg_ch     = 2'(ch);
        cfg_period = PERIOD_W'(per);
        cfg_enable = en;
        #1;
        exp_tick = (n % PRESCALE) == (PRESCALE - 1);
        for (int i = 0; i < NUM_CH; i++) begin
            exp_pulse[i] = m_wrapped[i];
            exp_pend[i]  = m_pend[i];
        end
        exp_ready = !m_pend[ch];

        compared += 4;
        if (tick_base !== exp_tick) begin
            mismatched++;
            $display("FAIL tick_base cycle %0d: got %b want %b", n, tick_base, exp_tick);
        end
        if (pulse !== exp_pulse) begin
            mismatched++;
            $display("FAIL pulse cycle %0d: got %b want %b", n, pulse, exp_pulse);
        end
        if (pending !== exp_pend) begin
            mismatched++;
            $display("FAIL pending cycle %0d: got %b want %b", n, pending, exp_pend);
        end
        if (cfg_ready !== exp_ready) begin
            mismatched++;
            $display("FAIL cfg_ready cycle %0d ch %0d: got %b want %b", n, ch, cfg_ready, exp_ready);
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (pulse[i] === 1'b1) begin
                if (last_pulse[i] >= 0) last_interval[i] = n - last_pulse[i];
                last_pulse[i] = n;
                pulse_count[i]++;
            end
            if (pending[i] === 1'b1) pend_seen[i] = 1;
        end

        acc = v && exp_ready;
        sat = (per == 0) ? 1 : per;
        k   = (n - (PRESCALE - 1)) / PRESCALE;
        for (int i = 0; i < NUM_CH; i++) begin
            wrap = m_on[i] && exp_tick && (k == m_next[i]);
            wr   = acc && (ch == i);
            m_wrapped[i] = wrap;
            if (wr && !en) begin
                m_on[i] = 0; m_pend[i] = 0;
            end else if (wr && !m_on[i]) begin
                m_on[i] = 1; m_per[i] = sat;
                m_next[i] = (n + 1) / PRESCALE + sat - 1;
            end else if (m_on[i]) begin
                if (wrap) begin
                    if (wr) m_per[i] = sat;
                    else if (m_pend[i]) begin m_per[i] = m_shadow[i]; m_pend[i] = 0; end
                    m_next[i] = m_next[i] + m_per[i];
                end else if (wr) begin
                    m_shadow[i] = sat; m_pend[i] = 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(40);
    endtask

    task automatic test_enable();
        step(1, 0, 3, 1);
        idle(40);
        compared++;
        if (last_interval[0] !== 12) begin
            mismatched++;
            $display("FAIL enable_interval ch0: got %0d want 12", last_interval[0]);
        end
        compared++;
        if (pulse_count[1] + pulse_count[2] + pulse_count[3] !== 0) begin
            mismatched++;
            $display("FAIL silent_channels: got %0d pulses want 0",
                     pulse_count[1] + pulse_count[2] + pulse_count[3]);
        end
    endtask

    task automatic test_period_change();
        int guard;
        while (n % PRESCALE == PRESCALE - 1) step(0, 0, 0, 0);
        step(1, 0, 5, 1);
        compared++;
        if (pending[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL pending_rise ch0: got %b want 1", pending[0]);
        end
        step(0, 1, 0, 0);  // cfg_ready must stay high for the other channel
        guard = 0;
        while (pending[0] === 1'b1 && guard < 40) begin
            step(0, 0, 0, 0);
            guard++;
        end
        compared++;
        if (guard >= 40 || last_interval[0] !== 12) begin
            mismatched++;
            $display("FAIL last_old_interval ch0: got %0d want 12 (guard %0d)", last_interval[0], guard);
        end
        idle(45);
        compared++;
        if (last_interval[0] !== 20) begin
            mismatched++;
            $display("FAIL new_interval ch0: got %0d want 20", last_interval[0]);
        end
    endtask

    task automatic test_coincident_wrap();
        int guard;
        step(1, 2, 3, 1);
        guard = 0;
        while (!((n % PRESCALE == PRESCALE - 1) && ((n - (PRESCALE - 1)) / PRESCALE == m_next[2]))
               && guard < 60) begin
            step(0, 0, 0, 0);
            guard++;
        end
        compared++;
        if (guard >= 60) begin
            mismatched++;
            $display("FAIL wrap_wait ch2: got timeout want wrap within 60 cycles");
        end
        pend_seen[2] = 0;
        step(1, 2, 2, 1);
        idle(30);
        compared++;
        if (pend_seen[2] !== 1'b0) begin
            mismatched++;
            $display("FAIL coincident_pending ch2: got %b want 0", pend_seen[2]);
        end
        compared++;
        if (last_interval[2] !== 8) begin
            mismatched++;
            $display("FAIL coincident_interval ch2: got %0d want 8", last_interval[2]);
        end
    endtask

    task automatic test_period_zero();
        int count_off;
        int e;
        int expect_pulse;
        int guard;
        step(1, 3, 0, 1);
        idle(20);
        compared++;
        if (last_interval[3] !== 4) begin
            mismatched++;
            $display("FAIL period_zero ch3: got %0d want 4", last_interval[3]);
        end
        while (n % PRESCALE == PRESCALE - 1) step(0, 0, 0, 0);
        step(1, 3, 1, 0);
        count_off = pulse_count[3];
        idle(20);
        compared++;
        if (pulse_count[3] !== count_off) begin
            mismatched++;
            $display("FAIL disabled_pulses ch3: got %0d want %0d", pulse_count[3], count_off);
        end
        e = n;
        step(1, 3, 2, 1);
        expect_pulse = ((e + 1) / PRESCALE + 1) * PRESCALE + (PRESCALE - 1) + 1;
        guard = 0;
        while (pulse_count[3] == count_off && guard < 20) begin
            step(0, 0, 0, 0);
            guard++;
        end
        compared++;
        if (last_pulse[3] !== expect_pulse) begin
            mismatched++;
            $display("FAIL reenable_first_pulse ch3: got cycle %0d want %0d", last_pulse[3], expect_pulse);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, NUM_CH - 1),
                 $urandom_range(0, 9), $urandom_range(0, 4) != 0);
        end
    endtask

    task automatic test_reset_midop();
        idle(2);
        if (!m_on[0]) step(1, 0, 3, 1);
        while (n % PRESCALE == PRESCALE - 1 || m_pend[0]) step(0, 0, 0, 0);
        step(1, 0, 6, 1);
        compared++;
        if (pending[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL pending_before_reset ch0: got %b want 1", pending[0]);
        end
        rst        = 1'b1;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd1;
        cfg_period = PERIOD_W'(2);
        cfg_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        cfg_valid = 1'b0;
        model_reset();
        idle(30);
        compared++;
        if (pulse_count[0] + pulse_count[1] !== 0) begin
            mismatched++;
            $display("FAIL discarded_write: got %0d pulses want 0", pulse_count[0] + pulse_count[1]);
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_period_change();
        test_coincident_wrap();
        test_period_zero();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel programmable tick generator: one shared prescaler divides `clk` down to a base tick, and up to `NUM_CH` channels each divide that base tick by a runtime-programmable period. Channel periods and enables are written over a valid/ready config port, and period changes on a running channel are deferred to its next wrap so no short or long pulse interval is ever produced. It replaces fixed-parameter dividers wherever firmware or a sequencer must retune tick rates (display refresh, scan timing) at run time.

## Interface
- `CLK_SPEED_HZ`, 1_000_000, input clock frequency.
- `BASE_HZ`, 1_000, base tick rate; `PRESCALE = CLK_SPEED_HZ / BASE_HZ`, must be >= 2 and divide exactly (elaboration error otherwise).
- `NUM_CH`, 4, number of channels, 1..16.
- `PERIOD_W`, 16, width of channel period in base ticks.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accepted when `cfg_valid & cfg_ready`.
- `cfg_ch` in max(1,$clog2(NUM_CH)): target channel; values >= NUM_CH are accepted and ignored.
- `cfg_period` in PERIOD_W: new period in base ticks; 0 treated as 1.
- `cfg_enable` in 1: 1 = run with `cfg_period`, 0 = stop channel.
- `tick_base` out 1: one-`clk` pulse at base rate.
- `pulse` out NUM_CH: per-channel one-`clk` output pulse.
- `pending` out NUM_CH: channel holds a deferred period update.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1, free-running, wraps to 0; `tick_base` = (pcnt == PRESCALE-1), combinational.
- Per channel: state OFF or RUN; registers `period`, `shadow`, `pending`, `cnt` (PERIOD_W bits).
- RUN: on each `tick_base`, if `cnt == period-1` (wrap) then `cnt <= 0` and pulse fires, else `cnt <= cnt+1`. OFF: `cnt` held at 0, no pulses.
- `cfg_ready = !pending[cfg_ch]` (1 for out-of-range `cfg_ch`).
- Accepted write, `cfg_enable=0`: channel -> OFF next cycle, `cnt`, `pending` cleared; takes effect immediately regardless of state.
- Accepted write, `cfg_enable=1`, channel OFF: `period <= max(cfg_period,1)`, `cnt <= 0`, -> RUN next cycle.
- Accepted write, `cfg_enable=1`, channel RUN: `shadow <= max(cfg_period,1)`, `pending <= 1`; at next wrap `period <= shadow`, `pending <= 0`, `cnt <= 0`. The wrap itself still fires a pulse under the old period.
- Write accepted in the same cycle as that channel's wrap: applied at that wrap (new period governs the very next interval); `pending` never rises.
- Channels are independent; all channels wrapping on the same `tick_base` pulse simultaneously.

## Timing
- Reset: `pcnt=0`, all channels OFF, `period=1`, `cnt=0`, `pending=0`; `pulse=0`, `tick_base=0`, `cfg_ready=1` in the cycle after reset is sampled.
- `tick_base` first high PRESCALE cycles after reset deasserts (pcnt reaches PRESCALE-1), then every PRESCALE cycles.
- `pulse[i]` registered: high exactly one cycle, the cycle after the `tick_base` cycle on which channel i wraps.
- From enable of an OFF channel with period P: first pulse follows the P-th subsequent `tick_base`; interval thereafter exactly P*PRESCALE clocks.
- Period change on RUN channel: last old interval completes fully; following interval is the new period; no interval shorter than min(old,new).
- `rst` mid-operation overrides all config writes and pending updates in that cycle.

## Structure
- Shared package `tick_sched_pkg`: channel state encoding (OFF/RUN), `prescale` constant function with exactness check, `sat_period` function (0 -> 1).
- Sub-module `tick_channel`: one channel's state, counter, shadow/pending logic and registered pulse; instantiated NUM_CH times via generate. Top holds prescaler, config decode, `cfg_ready` mux.

## Test plan
Bench parameters: CLK_SPEED_HZ=12, BASE_HZ=3 (PRESCALE=4), NUM_CH=4, PERIOD_W=8.
- Reset then idle 40 cycles -> `tick_base` every 4 cycles, first at cycle 3; `pulse`=0, `pending`=0, `cfg_ready`=1.
- Enable ch0 period 3 -> pulses every 12 clocks, first on the 3rd `tick_base` after accept +1 cycle; ch1..3 silent.
- Ch0 running period 3, write period 5 mid-interval -> `pending[0]`=1, `cfg_ready` low for ch0 only; next interval 12 clocks, then 20-clock intervals, `pending` clears at wrap.
- Write to ch2 period 2 timed to coincide with its wrap -> `pending[2]` never rises, next interval 8 clocks.
- Period 0 on ch3 -> behaves as period 1 (pulse every 4 clocks); disable ch3 mid-interval -> no further pulses, re-enable period 2 -> first pulse after 2 base ticks.
- Assert `rst` with ch0 pending and `cfg_valid` high -> all outputs 0, write discarded, `pending`=0 after reset.
